dm_arbiter: RTL and testbench

DM_ARBITER -- requirements
Module: dm_arbiter

---
 rtl/dm_arbiter.sv | 174 +++++++++++++++++
 tb/tb_dm_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port (CPU / debug loader) arbiter in front of a single data memory; all outputs registered.
// Ties are round-robin by default; define DM_ARB_FIXED_PRI_EN to make port A always win ties.
module dm_arbiter (
    input  logic        clk,
    input  logic        rst_f,
    input  logic        a_req,
    input  logic        b_req,
    input  logic        a_we,
    input  logic        b_we,
    input  logic [15:0] a_addr,
    input  logic [15:0] b_addr,
    input  logic [31:0] a_wdata,
    input  logic [31:0] b_wdata,
    output logic        a_ack,
    output logic        b_ack,
    output logic [31:0] rdata,
    output logic        busy,
    output logic [15:0] mem_read_addr,
    output logic [15:0] mem_write_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_dm_we,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WR_HI = 3'd2,
        S_WR_LO = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_win_b;
    logic        w_win_b_nxt;
    logic        r_last_b;
    logic        w_last_b_nxt;
    logic        r_a_ack;
    logic        w_a_ack_nxt;
    logic        r_b_ack;
    logic        w_b_ack_nxt;
    logic        r_busy;
    logic        w_busy_nxt;
    logic        r_dm_we;
    logic        w_dm_we_nxt;
    logic [31:0] r_rdata;
    logic [31:0] w_rdata_nxt;
    logic [15:0] r_raddr;
    logic [15:0] w_raddr_nxt;
    logic [15:0] r_waddr;
    logic [15:0] w_waddr_nxt;
    logic [31:0] r_wdata;
    logic [31:0] w_wdata_nxt;

    logic        w_pick_b;
    logic        w_sel_we;
    logic [15:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // Winner selection and request-field mux for the IDLE sampling edge.
    always_comb begin
`ifdef DM_ARB_FIXED_PRI_EN
        w_pick_b = b_req & ~a_req;
`else
        // r_last_b set means B went last, so a tie goes to A.
        w_pick_b = b_req & (~a_req | ~r_last_b);
`endif
        if (w_pick_b) begin
            w_sel_we    = b_we;
            w_sel_addr  = b_addr;
            w_sel_wdata = b_wdata;
        end else begin
            w_sel_we    = a_we;
            w_sel_addr  = a_addr;
            w_sel_wdata = a_wdata;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_win_b_nxt  = r_win_b;
        w_last_b_nxt = r_last_b;
        w_a_ack_nxt  = 1'b0;
        w_b_ack_nxt  = 1'b0;
        w_dm_we_nxt  = 1'b0;
        w_rdata_nxt  = r_rdata;
        w_raddr_nxt  = r_raddr;
        w_waddr_nxt  = r_waddr;
        w_wdata_nxt  = r_wdata;
        case (r_state)
            S_IDLE: begin
                if (a_req | b_req) begin
                    w_win_b_nxt  = w_pick_b;
                    w_last_b_nxt = w_pick_b;
                    w_raddr_nxt  = w_sel_addr;
                    w_waddr_nxt  = w_sel_addr;
                    w_wdata_nxt  = w_sel_wdata;
                    if (w_sel_we) begin
                        w_state_nxt = S_WR_HI;
                        w_dm_we_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_RD;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RD: begin
                w_rdata_nxt = mem_read_data;
                w_a_ack_nxt = ~r_win_b;
                w_b_ack_nxt = r_win_b;
                w_state_nxt = S_DONE;
            end
            // Leaving WR_HI lowers the strobe; memory commits on that falling edge.
            S_WR_HI: begin
                w_state_nxt = S_WR_LO;
            end
            S_WR_LO: begin
                w_a_ack_nxt = ~r_win_b;
                w_b_ack_nxt = r_win_b;
                w_state_nxt = S_DONE;
            end
            // Requests are deliberately not looked at here so a req dropped on ack is never re-served.
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_f) begin
            r_state  <= S_IDLE;
            r_win_b  <= 1'b0;
            r_last_b <= 1'b1;
            r_a_ack  <= 1'b0;
            r_b_ack  <= 1'b0;
            r_busy   <= 1'b0;
            r_dm_we  <= 1'b0;
            r_rdata  <= 32'h0000_0000;
            r_raddr  <= 16'h0000;
            r_waddr  <= 16'h0000;
            r_wdata  <= 32'h0000_0000;
        end else begin
            r_state  <= w_state_nxt;
            r_win_b  <= w_win_b_nxt;
            r_last_b <= w_last_b_nxt;
            r_a_ack  <= w_a_ack_nxt;
            r_b_ack  <= w_b_ack_nxt;
            r_busy   <= w_busy_nxt;
            r_dm_we  <= w_dm_we_nxt;
            r_rdata  <= w_rdata_nxt;
            r_raddr  <= w_raddr_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
        end
    end

    assign a_ack          = r_a_ack;
    assign b_ack          = r_b_ack;
    assign rdata          = r_rdata;
    assign busy           = r_busy;
    assign mem_dm_we      = r_dm_we;
    assign mem_read_addr  = r_raddr;
    assign mem_write_addr = r_waddr;
    assign mem_write_data = r_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: transaction-level reference model (grant rules, fixed
// latencies, word memory) compared every cycle, plus directed scenarios and randomized traffic.
module tb_dm_arbiter;

    logic        clk;
    logic        rst_f;
    logic        a_req, b_req, a_we, b_we;
    logic [15:0] a_addr, b_addr;
    logic [31:0] a_wdata, b_wdata;
    logic        a_ack, b_ack, busy, mem_dm_we;
    logic [31:0] rdata, mem_write_data, mem_read_data;
    logic [15:0] mem_read_addr, mem_write_addr;

    int n_checks;
    int n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    dm_arbiter u_dut (
        .clk            (clk),
        .rst_f          (rst_f),
        .a_req          (a_req),
        .b_req          (b_req),
        .a_we           (a_we),
        .b_we           (b_we),
        .a_addr         (a_addr),
        .b_addr         (b_addr),
        .a_wdata        (a_wdata),
        .b_wdata        (b_wdata),
        .a_ack          (a_ack),
        .b_ack          (b_ack),
        .rdata          (rdata),
        .busy           (busy),
        .mem_read_addr  (mem_read_addr),
        .mem_write_addr (mem_write_addr),
        .mem_write_data (mem_write_data),
        .mem_dm_we      (mem_dm_we),
        .mem_read_data  (mem_read_data)
    );

    // Data memory: combinational read, write committed on the falling edge of the strobe.
    logic [31:0] mem [0:65535];
    logic [15:0] cap_addr;
    logic [31:0] cap_data;
    assign mem_read_data = mem[mem_read_addr];
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        forever begin
            @(posedge mem_dm_we);
            cap_addr = mem_write_addr;
            cap_data = mem_write_data;
            @(negedge mem_dm_we);
            mem[cap_addr] = cap_data;
        end
    end

    // Reference model state (edge-indexed).
    int          cyc;
    int          free_at, a_ack_at, b_ack_at, we_at;
    bit          last_b;
    bit   [31:0] exp_rdata, flight_rd;
    bit          flight_is_rd;
    bit   [31:0] ref_mem [int];
    // Requester intent
    bit          pa, pb, a_svc, b_svc;
    bit          ta_we, tb_we;
    bit   [15:0] ta_addr, tb_addr;
    bit   [31:0] ta_wd, tb_wd;
    // Observed DUT activity
    int          n_a_ack, n_b_ack, n_we_hi, last_a_ack_cyc, last_b_ack_cyc;
    bit          ack_log [$];

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic bit pick_b(input bit ra, input bit rb, input bit lb);
`ifdef DM_ARB_FIXED_PRI_EN
        return rb && !ra;
`else
        if (ra && rb) return !lb;
        return rb;
`endif
    endfunction

    function automatic bit [15:0] rand_addr();
        int unsigned p;
        p = $urandom_range(0, 9);
        if (p == 8) return 16'hFFFF;
        if (p == 9) return 16'h8000;
        return 16'(p);
    endfunction

    // Fields of a request already granted are scrambled: the DUT must have latched them.
    task automatic drive_pins();
        a_req = pa;
        b_req = pb;
        if (a_svc) begin
            a_we = 1'($urandom); a_addr = 16'($urandom); a_wdata = $urandom;
        end else begin
            a_we = ta_we; a_addr = ta_addr; a_wdata = ta_wd;
        end
        if (b_svc) begin
            b_we = 1'($urandom); b_addr = 16'($urandom); b_wdata = $urandom;
        end else begin
            b_we = tb_we; b_addr = tb_addr; b_wdata = tb_wd;
        end
    endtask

    task automatic step();
        bit        rst_now, granted, g_b, g_we;
        bit [15:0] g_addr;
        bit [31:0] g_wd;
        int        ack_edge;
        rst_now = !rst_f;
        granted = 1'b0; g_b = 1'b0; g_we = 1'b0; g_addr = 16'h0; g_wd = 32'h0; ack_edge = 0;
        @(posedge clk);
        cyc++;
        if (rst_now) begin
            free_at = cyc + 1; a_ack_at = -10; b_ack_at = -10; we_at = -10;
            last_b = 1'b1; exp_rdata = 32'h0; a_svc = 1'b0; b_svc = 1'b0;
        end else if (cyc >= free_at && (pa || pb)) begin
            granted = 1'b1;
            g_b     = pick_b(pa, pb, last_b);
            last_b  = g_b;
            g_we    = g_b ? tb_we : ta_we;
            g_addr  = g_b ? tb_addr : ta_addr;
            g_wd    = g_b ? tb_wd : ta_wd;
            if (g_we) begin
                ref_mem[int'(g_addr)] = g_wd;
                we_at = cyc; ack_edge = cyc + 2; free_at = cyc + 4;
            end else begin
                flight_rd = ref_mem.exists(int'(g_addr)) ? ref_mem[int'(g_addr)] : 32'h0;
                ack_edge = cyc + 1; free_at = cyc + 3;
            end
            flight_is_rd = !g_we;
            if (g_b) begin b_ack_at = ack_edge; b_svc = 1'b1; end
            else begin a_ack_at = ack_edge; a_svc = 1'b1; end
        end
        if (flight_is_rd && (a_ack_at == cyc || b_ack_at == cyc)) exp_rdata = flight_rd;
        #1;
        check_value("a_ack", 32'(a_ack), 32'(a_ack_at == cyc));
        check_value("b_ack", 32'(b_ack), 32'(b_ack_at == cyc));
        check_value("mem_dm_we", 32'(mem_dm_we), 32'(we_at == cyc));
        check_value("busy", 32'(busy), 32'(cyc <= free_at - 2));
        check_value("rdata", rdata, exp_rdata);
        if (rst_now) begin
            check_value("rst_mem_read_addr", 32'(mem_read_addr), 32'h0);
            check_value("rst_mem_write_addr", 32'(mem_write_addr), 32'h0);
            check_value("rst_mem_write_data", mem_write_data, 32'h0);
        end
        if (granted) begin
            check_value("grant_read_addr", 32'(mem_read_addr), 32'(g_addr));
            check_value("grant_write_addr", 32'(mem_write_addr), 32'(g_addr));
            check_value("grant_write_data", mem_write_data, g_wd);
        end
        if (a_ack) begin n_a_ack++; last_a_ack_cyc = cyc; ack_log.push_back(1'b0); end
        if (b_ack) begin n_b_ack++; last_b_ack_cyc = cyc; ack_log.push_back(1'b1); end
        if (mem_dm_we) n_we_hi++;
        if (a_ack_at == cyc) begin pa = 1'b0; a_svc = 1'b0; end
        if (b_ack_at == cyc) begin pb = 1'b0; b_svc = 1'b0; end
        drive_pins();
    endtask

    task automatic settle();
        for (int i = 0; i < 8 && cyc + 1 < free_at; i++) step();
    endtask

    initial begin
        int t0, na0, nb0, we0, first_a, first_b;
        n_checks = 0; n_errors = 0;
        cyc = 0; free_at = 0; a_ack_at = -10; b_ack_at = -10; we_at = -10;
        last_b = 1'b1; exp_rdata = 32'h0; flight_rd = 32'h0; flight_is_rd = 1'b0;
        pa = 1'b0; pb = 1'b0; a_svc = 1'b0; b_svc = 1'b0;
        ta_we = 1'b0; tb_we = 1'b0; ta_addr = 16'h0; tb_addr = 16'h0; ta_wd = 32'h0; tb_wd = 32'h0;
        n_a_ack = 0; n_b_ack = 0; n_we_hi = 0; last_a_ack_cyc = -1; last_b_ack_cyc = -1;
        rst_f = 1'b0;
        drive_pins();
        repeat (2) step();
        rst_f = 1'b1;

        // A writes DEADBEEF to word 4
        pa = 1'b1; ta_we = 1'b1; ta_addr = 16'h0004; ta_wd = 32'hDEADBEEF; drive_pins();
        t0 = cyc; we0 = n_we_hi;
        repeat (6) step();
        check_value("wr_ack_edge", 32'(last_a_ack_cyc - t0), 32'd3);
        check_value("wr_we_cycles", 32'(n_we_hi - we0), 32'd1);
        check_value("wr_mem_word4", mem[16'h0004], 32'hDEADBEEF);

        // A reads word 4 back
        pa = 1'b1; ta_we = 1'b0; ta_addr = 16'h0004; drive_pins();
        t0 = cyc; we0 = n_we_hi;
        repeat (5) step();
        check_value("rd_ack_edge", 32'(last_a_ack_cyc - t0), 32'd2);
        check_value("rd_rdata", rdata, 32'hDEADBEEF);
        check_value("rd_we_cycles", 32'(n_we_hi - we0), 32'd0);

        // Held simultaneous reads right after reset
        rst_f = 1'b0; step(); rst_f = 1'b1;
        ack_log.delete();
        na0 = n_a_ack; nb0 = n_b_ack; first_a = -1; first_b = -1;
        pa = 1'b1; ta_we = 1'b0; ta_addr = 16'h0004;
        pb = 1'b1; tb_we = 1'b0; tb_addr = 16'h0000; drive_pins();
        for (int i = 0; i < 16; i++) begin
            step();
            if (first_a < 0 && n_a_ack > na0) first_a = last_a_ack_cyc;
            if (first_b < 0 && n_b_ack > nb0) first_b = last_b_ack_cyc;
            if (!pa) pa = 1'b1;
            if (!pb) pb = 1'b1;
            drive_pins();
        end
        check_value("tie_ack_count", 32'(ack_log.size() >= 4), 32'd1);
        for (int i = 0; i < 4 && i < ack_log.size(); i++) begin
`ifdef DM_ARB_FIXED_PRI_EN
            check_value("tie_order", 32'(ack_log[i]), 32'd0);
`else
            check_value("tie_order", 32'(ack_log[i]), 32'(i % 2));
`endif
        end
`ifndef DM_ARB_FIXED_PRI_EN
        check_value("tie_b_delay", 32'(first_b - first_a), 32'd3);
`endif
        repeat (10) step();

        // Reset while the write strobe is high
        settle();
        pa = 1'b1; ta_we = 1'b1; ta_addr = 16'h0008; ta_wd = 32'h12345678; drive_pins();
        step();
        rst_f = 1'b0; pa = 1'b0; drive_pins();
        na0 = n_a_ack;
        step();
        rst_f = 1'b1;
        repeat (3) step();
        check_value("rst_wr_no_ack", 32'(n_a_ack - na0), 32'd0);
        check_value("rst_wr_word8", mem[16'h0008], 32'h12345678);

        // Requester drops req in the ack cycle
        settle();
        pa = 1'b1; ta_we = 1'b0; ta_addr = 16'hFFFF; drive_pins();
        na0 = n_a_ack;
        repeat (4) step();
        check_value("drop_busy_low", 32'(busy), 32'd0);
        repeat (4) step();
        check_value("drop_one_ack", 32'(n_a_ack - na0), 32'd1);

        // B writes to the top address
        settle();
        pb = 1'b1; tb_we = 1'b1; tb_addr = 16'hFFFF; tb_wd = 32'h00000001; drive_pins();
        t0 = cyc; na0 = n_a_ack;
        repeat (5) step();
        check_value("b_wr_ack_edge", 32'(last_b_ack_cyc - t0), 32'd3);
        check_value("b_wr_no_a_ack", 32'(n_a_ack - na0), 32'd0);
        check_value("b_wr_mem_ffff", mem[16'hFFFF], 32'h00000001);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            if (!pa && $urandom_range(0, 2) == 0) begin
                pa = 1'b1; ta_we = 1'($urandom_range(0, 1)); ta_addr = rand_addr(); ta_wd = $urandom;
            end
            if (!pb && $urandom_range(0, 2) == 0) begin
                pb = 1'b1; tb_we = 1'($urandom_range(0, 1)); tb_addr = rand_addr(); tb_wd = $urandom;
            end
            rst_f = ($urandom_range(0, 59) != 0);
            drive_pins();
            step();
        end
        rst_f = 1'b1;
        drive_pins();
        repeat (12) step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
